// File: rtl/posit_encode_round_if.sv
// Handshake and field bundle between the posit adder/multiplier and the encoder/rounder.
// With POSIT_ENC_FLAGS_EN defined the sticky exception flags and their clear travel here too.
interface posit_encode_round_if #(
  parameter int N   = 16,
  parameter int SFW = N - 9
);
  logic           i_valid;
  logic           o_ready;
  logic           i_s;
  logic [SFW-1:0] i_sf;
  logic [N-5:0]   i_mant;
  logic           i_guard;
  logic           i_sticky;
  logic           i_nzn;
  logic           o_valid;
  logic           i_ready;
  logic [N-1:0]   o_posit;
`ifdef POSIT_ENC_FLAGS_EN
  logic           o_inexact;
  logic           o_sat;
  logic           i_flag_clr;

  modport slave (
    input  i_valid, i_s, i_sf, i_mant, i_guard, i_sticky, i_nzn, i_ready, i_flag_clr,
    output o_ready, o_valid, o_posit, o_inexact, o_sat
  );
  modport master (
    output i_valid, i_s, i_sf, i_mant, i_guard, i_sticky, i_nzn, i_ready, i_flag_clr,
    input  o_ready, o_valid, o_posit, o_inexact, o_sat
  );
`else
  modport slave (
    input  i_valid, i_s, i_sf, i_mant, i_guard, i_sticky, i_nzn, i_ready,
    output o_ready, o_valid, o_posit
  );
  modport master (
    output i_valid, i_s, i_sf, i_mant, i_guard, i_sticky, i_nzn, i_ready,
    input  o_ready, o_valid, o_posit
  );
`endif
endinterface

// File: rtl/posit_encode_round.sv
// Two-stage posit<N,1> encoder with round-to-nearest-even and posit saturation.
// Optional sticky inexact/saturation flags are built when POSIT_ENC_FLAGS_EN is defined.
module posit_encode_round #(
  parameter int N   = 16,
  parameter int SFW = N - 9
) (
  input logic                  i_clk,
  input logic                  i_rst,
  posit_encode_round_if.slave  bus
);
  localparam int FW  = N - 4;    // fraction width
  localparam int TW  = FW + 3;   // exponent, fraction, guard, sticky
  localparam int BW  = N - 1;    // posit body below the sign bit
  localparam int XW  = 2 * N;    // regime + tail after the widest legal shift
  localparam int SMW = SFW + 1;  // scale factor plus room for the negation carry

  localparam logic signed [SMW-1:0] SAT_HI = SMW'(2 * N - 4);
  localparam logic signed [SMW-1:0] SAT_LO = SMW'(-(2 * N - 4));
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = N'(1);

  typedef enum logic [1:0] {SAT_NONE, SAT_MAX, SAT_MIN} sat_e;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_s_q, s1_s_d;
  logic          s1_zero_q, s1_zero_d;
  logic          s1_nar_q, s1_nar_d;
  sat_e          s1_sat_q, s1_sat_d;
  logic [XW-1:0] s1_full_q, s1_full_d;
  logic          s2_valid_q, s2_valid_d;
  logic [N-1:0]  posit_q, posit_d;

  logic                  ready;
  logic                  s1_load;
  logic                  s2_en;
  logic                  s2_load;
  logic [FW+1:0]         fgs;
  logic [FW+2:0]         fgs_neg;
  logic [FW+1:0]         frac_m;
  logic signed [SMW-1:0] sf_ext;
  logic signed [SMW-1:0] sf_m;
  logic signed [SMW-1:0] k;
  logic [SMW-1:0]        shamt;
  logic [XW-1:0]         seed;
  logic [XW-1:0]         full;
  sat_e                  sat_c;

  logic [BW-1:0] body;
  logic          rnd_g;
  logic          rnd_s;
  logic          inc;
  logic [N-1:0]  sum;
  logic          clamp;
  logic [N-1:0]  mag;
  logic [N-1:0]  word;

  // Stage 1: magnitude conversion and regime placement.
  always_comb begin
    fgs     = {bus.i_mant, bus.i_guard, bus.i_sticky};
    fgs_neg = {1'b0, ~fgs} + (FW+3)'(1);
    sf_ext  = {bus.i_sf[SFW-1], bus.i_sf};
    frac_m  = fgs;
    sf_m    = sf_ext;
    if (bus.i_s) begin
      if (fgs_neg[FW+2]) begin
        sf_m   = sf_ext + SMW'(1);
        frac_m = '0;
      end else begin
        frac_m = fgs_neg[FW+1:0];
      end
    end
    k = sf_m >>> 1;
    // For negative k, ~k == -k-1: the seed already carries one leading zero.
    shamt = k[SMW-1] ? ~k : k;
    if (k[SMW-1]) begin
      seed = {2'b01, sf_m[0], frac_m, {(XW-2-TW){1'b0}}};
      full = seed >> shamt;
    end else begin
      seed = {2'b10, sf_m[0], frac_m, {(XW-2-TW){1'b0}}};
      full = $signed(seed) >>> shamt;
    end
    sat_c = SAT_NONE;
    if (sf_m >= SAT_HI) begin
      sat_c = SAT_MAX;
    end else if (sf_m < SAT_LO) begin
      sat_c = SAT_MIN;
    end
  end

  // Stage 2: round to nearest even, saturate, apply sign and specials.
  always_comb begin
    body  = s1_full_q[XW-1 -: BW];
    rnd_g = s1_full_q[XW-1-BW];
    rnd_s = |s1_full_q[XW-2-BW:0];
    inc   = rnd_g & (rnd_s | body[0]);
    sum   = {1'b0, body} + N'(inc);
    clamp = sum[N-1];
    mag   = clamp ? MAXPOS : sum;
    if (s1_sat_q == SAT_MAX) begin
      mag = MAXPOS;
    end else if (s1_sat_q == SAT_MIN) begin
      mag = MINPOS;
    end
    word = s1_s_q ? (~mag + N'(1)) : mag;
    if (s1_zero_q) begin
      word = '0;
    end else if (s1_nar_q) begin
      word = {1'b1, {(N-1){1'b0}}};
    end
  end

  always_comb begin
    ready      = ~s1_valid_q | ~s2_valid_q | bus.i_ready;
    s1_load    = ready & bus.i_valid;
    s2_en      = ~s2_valid_q | bus.i_ready;
    s2_load    = s2_en & s1_valid_q;
    s1_valid_d = ready ? bus.i_valid : s1_valid_q;
    s1_s_d     = s1_load ? bus.i_s : s1_s_q;
    s1_zero_d  = s1_load ? (~bus.i_nzn & ~bus.i_s) : s1_zero_q;
    s1_nar_d   = s1_load ? (~bus.i_nzn & bus.i_s) : s1_nar_q;
    s1_sat_d   = s1_load ? sat_c : s1_sat_q;
    s1_full_d  = s1_load ? full : s1_full_q;
    s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
    posit_d    = s2_load ? word : posit_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_sat_q   <= SAT_NONE;
      s1_full_q  <= '0;
      s2_valid_q <= 1'b0;
      posit_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_s_q     <= s1_s_d;
      s1_zero_q  <= s1_zero_d;
      s1_nar_q   <= s1_nar_d;
      s1_sat_q   <= s1_sat_d;
      s1_full_q  <= s1_full_d;
      s2_valid_q <= s2_valid_d;
      posit_q    <= posit_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = s2_valid_q;
  assign bus.o_posit = posit_q;

`ifdef POSIT_ENC_FLAGS_EN
  logic s2_inexact_q, s2_inexact_d;
  logic s2_sat_q, s2_sat_d;
  logic flag_inexact_q, flag_inexact_d;
  logic flag_sat_q, flag_sat_d;
  logic special;
  logic out_xfer;

  // Per-item exception bits ride with the word; sticky flags latch on output transfer.
  always_comb begin
    special        = s1_zero_q | s1_nar_q;
    out_xfer       = s2_valid_q & bus.i_ready;
    s2_inexact_d   = s2_load ? (~special & (s1_sat_q == SAT_NONE) & (rnd_g | rnd_s)) : s2_inexact_q;
    s2_sat_d       = s2_load ? (~special & ((s1_sat_q != SAT_NONE) | clamp)) : s2_sat_q;
    flag_inexact_d = flag_inexact_q | (out_xfer & s2_inexact_q);
    flag_sat_d     = flag_sat_q | (out_xfer & s2_sat_q);
    if (bus.i_flag_clr) begin
      flag_inexact_d = 1'b0;
      flag_sat_d     = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_inexact_q   <= 1'b0;
      s2_sat_q       <= 1'b0;
      flag_inexact_q <= 1'b0;
      flag_sat_q     <= 1'b0;
    end else begin
      s2_inexact_q   <= s2_inexact_d;
      s2_sat_q       <= s2_sat_d;
      flag_inexact_q <= flag_inexact_d;
      flag_sat_q     <= flag_sat_d;
    end
  end

  assign bus.o_inexact = flag_inexact_q;
  assign bus.o_sat     = flag_sat_q;
`endif
endmodule
